// File: rtl/fsm_updown_counter_arbiter.sv
// Two-requester round-robin arbiter that steers an external 2-bit up/down counter
// to a requested value along the shortest modulo-4 path, with a per-request step limit.
module fsm_updown_counter_arbiter #(
  parameter int STEP_LIMIT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [1:0] req0_target,
  input  logic [1:0] req1_target,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [1:0] cnt_q,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       done,
  output logic       done_id,
  output logic       err,
  output logic       busy
);

  localparam int CW = (STEP_LIMIT < 1) ? 1 : $clog2(STEP_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, MOVE, DONE, ERR} state_t;

  state_t        state;
  logic          ptr;
  logic [1:0]    tgt;
  logic          id;
  logic [CW-1:0] steps;

  logic       grant0;
  logic       grant1;
  logic       at_target;
  logic       limit_hit;
  logic [1:0] up_dist;

  // Grants are gated by rst_n so the ready outputs are 0 for the whole reset period.
  always_comb begin
    grant0    = rst_n && (state == IDLE) && req0_valid && (!req1_valid || !ptr);
    grant1    = rst_n && (state == IDLE) && req1_valid && (!req0_valid || ptr);
    at_target = (cnt_q == tgt);
    up_dist   = tgt - cnt_q;
    limit_hit = (steps == CW'(STEP_LIMIT));
    cnt_en    = (state == MOVE) && !at_target && !limit_hit;
    cnt_dir   = cnt_en && (up_dist <= 2'd2);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      tgt     <= 2'd0;
      id      <= 1'b0;
      steps   <= '0;
      done    <= 1'b0;
      done_id <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      done    <= 1'b0;
      err     <= 1'b0;
      done_id <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            tgt   <= grant0 ? req0_target : req1_target;
            id    <= grant1;
            ptr   <= grant0;
            steps <= '0;
            busy  <= 1'b1;
            state <= MOVE;
          end
        end
        MOVE: begin
          // Reaching the target takes precedence, so a move finishing on the last
          // allowed step still completes rather than erroring.
          if (at_target) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= id;
          end else if (limit_hit) begin
            state   <= ERR;
            err     <= 1'b1;
            done_id <= id;
          end else begin
            steps <= steps + CW'(1);
          end
        end
        DONE, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_updown_counter_arbiter.sv
// Scoreboard bench: tasks queue the expected service order, a negedge monitor checks
// grants, step count/direction, completion latency and pulses; the bench also models the counter.
module tb_fsm_updown_counter_arbiter;

  localparam int STEP_LIMIT = 3;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic       req1_valid;
  logic [1:0] req0_target;
  logic [1:0] req1_target;
  logic       req0_ready;
  logic       req1_ready;
  logic [1:0] cnt_q;
  logic       cnt_en;
  logic       cnt_dir;
  logic       done;
  logic       done_id;
  logic       err;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit id;
    int steps;
    bit is_err;
    bit dir;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   active;
  bit   stuck;
  bit   acc_pending;
  bit   acc_id;
  bit   en_s;
  bit   dir_s;
  int   en_cnt;
  int   age;

  fsm_updown_counter_arbiter #(.STEP_LIMIT(STEP_LIMIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_target (req0_target),
    .req1_target (req1_target),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .cnt_q       (cnt_q),
    .cnt_en      (cnt_en),
    .cnt_dir     (cnt_dir),
    .done        (done),
    .done_id     (done_id),
    .err         (err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t make_exp(bit rid, logic [1:0] c, logic [1:0] t, bit stk);
    exp_t e;
    logic [1:0] d;
    d        = t - c;
    e.id     = rid;
    e.dir    = (d <= 2'd2);
    e.is_err = 1'b0;
    if (d == 2'd0)
      e.steps = 0;
    else if (stk) begin
      e.steps  = STEP_LIMIT;
      e.is_err = 1'b1;
    end else
      e.steps = (d <= 2'd2) ? int'(d) : 4 - int'(d);
    return e;
  endfunction

  // Monitor and external counter model.
  always @(negedge clk) begin
    if (!rst_n) begin
      active      = 1'b0;
      acc_pending = 1'b0;
    end else begin
      checks++;
      if ((done && err) || (done && cnt_en) || (err && cnt_en)) begin
        failures++;
        $display("[TB] FAIL exclusive: done=%0b err=%0b cnt_en=%0b required at most one", done, err, cnt_en);
      end
      if (req0_ready || req1_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_grant: ready0=%0b ready1=%0b required none", req0_ready, req1_ready);
        end else if (req0_ready && req1_ready) begin
          failures++;
          $display("[TB] FAIL double_grant: ready0=1 ready1=1 required one");
        end else begin
          cur = sb[0];
          if (req1_ready !== cur.id) begin
            failures++;
            $display("[TB] FAIL grant_id: got %0b required %0b", req1_ready, cur.id);
          end
          active      = 1'b1;
          en_cnt      = 0;
          age         = 0;
          acc_pending = 1'b1;
          acc_id      = req1_ready;
        end
      end else if (active) begin
        age++;
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL busy_active: got %0b required 1", busy);
        end
        if (cnt_en) begin
          en_cnt++;
          checks++;
          if (cnt_dir !== cur.dir) begin
            failures++;
            $display("[TB] FAIL cnt_dir: got %0b required %0b", cnt_dir, cur.dir);
          end
        end
        if (done || err) begin
          checks++;
          if (err !== cur.is_err || done_id !== cur.id || en_cnt != cur.steps || age != cur.steps + 2) begin
            failures++;
            $display("[TB] FAIL completion: err=%0b id=%0b steps=%0d age=%0d required err=%0b id=%0b steps=%0d age=%0d",
                     err, done_id, en_cnt, age, cur.is_err, cur.id, cur.steps, cur.steps + 2);
          end
          void'(sb.pop_front());
          active = 1'b0;
        end else if (age > STEP_LIMIT + 4) begin
          failures++;
          $display("[TB] FAIL no_completion: age=%0d required <= %0d", age, STEP_LIMIT + 2);
          void'(sb.pop_front());
          active = 1'b0;
        end
      end
      en_s  = cnt_en;
      dir_s = cnt_dir;
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (en_s && !stuck)
          cnt_q = dir_s ? cnt_q + 2'd1 : cnt_q - 2'd1;
        if (acc_pending) begin
          if (acc_id) req1_valid = 1'b0;
          else        req0_valid = 1'b0;
          acc_pending = 1'b0;
        end
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 80 && sb.size() != 0; i++)
      @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL timeout: pending=%0d required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    checks++;
    if ({cnt_en, cnt_dir, done, done_id, err, busy, req0_ready, req1_ready} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b required 00000000",
               {cnt_en, cnt_dir, done, done_id, err, busy, req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %0b required 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_contention();
    cnt_q       = 2'd0;
    sb.push_back(make_exp(1'b0, 2'd0, 2'd1, 1'b0));
    sb.push_back(make_exp(1'b1, 2'd1, 2'd3, 1'b0));
    req0_target = 2'd1;
    req1_target = 2'd3;
    req0_valid  = 1'b1;
    req1_valid  = 1'b1;
    wait_done();
    sb.push_back(make_exp(1'b0, 2'd3, 2'd0, 1'b0));
    sb.push_back(make_exp(1'b1, 2'd0, 2'd2, 1'b0));
    req0_target = 2'd0;
    req1_target = 2'd2;
    req0_valid  = 1'b1;
    req1_valid  = 1'b1;
    wait_done();
    checks++;
    if (cnt_q !== 2'd2) begin
      failures++;
      $display("[TB] FAIL contention_final_cnt: got %0d required 2", cnt_q);
    end
  endtask

  task automatic test_single();
    cnt_q = 2'd0;
    sb.push_back(make_exp(1'b0, 2'd0, 2'd2, 1'b0));
    req0_target = 2'd2;
    req0_valid  = 1'b1;
    wait_done();
  endtask

  task automatic test_wrap();
    cnt_q = 2'd0;
    sb.push_back(make_exp(1'b1, 2'd0, 2'd3, 1'b0));
    req1_target = 2'd3;
    req1_valid  = 1'b1;
    wait_done();
    checks++;
    if (cnt_q !== 2'd3) begin
      failures++;
      $display("[TB] FAIL wrap_final_cnt: got %0d required 3", cnt_q);
    end
  endtask

  task automatic test_zero_tie();
    cnt_q = 2'd1;
    sb.push_back(make_exp(1'b0, 2'd1, 2'd1, 1'b0));
    req0_target = 2'd1;
    req0_valid  = 1'b1;
    wait_done();
    cnt_q = 2'd1;
    sb.push_back(make_exp(1'b1, 2'd1, 2'd3, 1'b0));
    req1_target = 2'd3;
    req1_valid  = 1'b1;
    wait_done();
  endtask

  task automatic test_stuck();
    stuck = 1'b1;
    cnt_q = 2'd0;
    sb.push_back(make_exp(1'b0, 2'd0, 2'd1, 1'b1));
    req0_target = 2'd1;
    req0_valid  = 1'b1;
    wait_done();
    stuck = 1'b0;
  endtask

  task automatic test_async_reset();
    cnt_q = 2'd0;
    sb.push_back(make_exp(1'b1, 2'd0, 2'd2, 1'b0));
    req1_target = 2'd2;
    req1_valid  = 1'b1;
    for (int i = 0; i < 10 && !busy; i++)
      @(negedge clk);
    @(posedge clk);
    #3;
    checks++;
    if (cnt_en !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_move_cnt_en: got %0b required 1", cnt_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt_en, cnt_dir, done, done_id, err, busy, req0_ready, req1_ready} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs: got %b required 00000000",
               {cnt_en, cnt_dir, done, done_id, err, busy, req0_ready, req1_ready});
    end
    sb.delete();
    req1_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: busy=%0b done=%0b err=%0b required 0 0 0", busy, done, err);
    end
    @(posedge clk);
    #1;
    sb.push_back(make_exp(1'b0, cnt_q, 2'd3, 1'b0));
    req0_target = 2'd3;
    req0_valid  = 1'b1;
    wait_done();
  endtask

  initial begin
    rst_n       = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_target = 2'd0;
    req1_target = 2'd0;
    cnt_q       = 2'd0;
    stuck       = 1'b0;
    active      = 1'b0;
    acc_pending = 1'b0;
    test_reset();
    test_contention();
    test_single();
    test_wrap();
    test_zero_tie();
    test_stuck();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_updown_counter_arbiter.md
FSM_UPDOWN_COUNTER_ARBITER -- requirements
Module: fsm_updown_counter_arbiter

Interface
REQ-001 SHALL have parameter: STEP_LIMIT, default 3, maximum counter steps per request before an error is flagged.
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1 each  requester wants the counter moved.
REQ-005 SHALL have ports: req0_target, req1_target  input  2 each  requested counter value.
REQ-006 SHALL have ports: req0_ready, req1_ready  output  1 each  request accepted this cycle.
REQ-007 SHALL have port: cnt_q  input  2  present value of the external 2-bit up/down counter.
REQ-008 SHALL have port: cnt_en  output  1  counter steps once at the next rising edge when high.
REQ-009 SHALL have port: cnt_dir  output  1  step direction (1 = up, 0 = down); valid only when cnt_en = 1.
REQ-010 SHALL have ports: done  output  1  one-cycle pulse when target reached; done_id  output  1  requester served.
REQ-011 SHALL have ports: err  output  1  one-cycle pulse on step-limit overrun; busy  output  1  high when state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, MOVE, DONE, ERR.
REQ-013 IDLE: SHALL accept at most one request per cycle; a request is accepted when its valid is high and it wins arbitration.
REQ-014 Accepting a request SHALL drive the winner's ready high combinationally in that cycle, latch its target and id, clear the step count, and go to MOVE.
REQ-015 req*_ready SHALL be low in every state other than IDLE; valid requests in other states SHALL be held off, not dropped.
REQ-016 Arbitration SHALL be round-robin with a 1-bit priority pointer: a sole valid requester wins; when both are valid, the pointer holder wins; after each grant the pointer SHALL move to the other requester.
REQ-017 MOVE, when cnt_q == latched target: SHALL hold cnt_en = 0 and go to DONE next cycle; this covers zero-step requests.
REQ-018 MOVE, when cnt_q != target and step count < STEP_LIMIT: SHALL assert cnt_en = 1 and increment the step count.
REQ-019 Direction SHALL be the shortest modulo-4 path: up_dist = (target - cnt_q) mod 4; cnt_dir = 1 if up_dist <= 2, else 0, so a tie at distance 2 goes up.
REQ-020 Wrap-around (3->0 up, 0->3 down) SHALL be treated as a normal single step.
REQ-021 MOVE, when cnt_q != target and step count == STEP_LIMIT: SHALL hold cnt_en = 0 and go to ERR.
REQ-022 DONE: SHALL assert done = 1 and done_id = latched id for exactly one cycle, then return to IDLE.
REQ-023 ERR: SHALL assert err = 1 and done_id = latched id for exactly one cycle, then return to IDLE.
REQ-024 Latency: for a request accepted at edge N with distance k, cnt_en SHALL be high in cycles N+1..N+k and done SHALL be high in cycle N+k+2.
REQ-025 done, err and cnt_en SHALL never be high in the same cycle.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, priority pointer to requester 0, step count 0, latched target 0, latched id 0.
REQ-028 While rst_n is low, all outputs SHALL be 0 (cnt_en, cnt_dir, done, done_id, err, busy, req0_ready, req1_ready).
REQ-029 Reset asserted mid-MOVE SHALL abort the request with no done or err pulse; the requester SHALL re-present the request after reset.

Verification
REQ-030 Single request: cnt_q = 0, req0 target 2 -> cnt_en high 2 cycles with cnt_dir = 1, then done = 1 with done_id = 0.
REQ-031 Wrap: cnt_q = 0, req1 target 3 -> exactly 1 step with cnt_dir = 0 (0->3), then done with done_id = 1.
REQ-032 Zero-step and tie: target equal to cnt_q -> no cnt_en, done 2 cycles after accept; cnt_q = 1, target 3 -> 2 steps up.
REQ-033 Contention: both valid after reset -> req0 served first, then req1; both valid again -> req0 served again (pointer returned to 0).
REQ-034 Stuck counter: cnt_q held at 0, target 1 -> 3 cnt_en cycles, then err = 1 and no done.
REQ-035 Async reset: rst_n driven low mid-MOVE between clock edges -> all outputs 0 immediately; after release, busy = 0 and a new request completes normally.
